// File: rtl/cpu_pkg.sv
// Shared CPU-side constants and the fetch queue entry type.
package cpu_pkg;

    localparam int unsigned INST_W  = 32;
    localparam int unsigned PC_W    = 32;
    localparam int unsigned PC_STEP = 4;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched instructions; flush empties it and wins over push/pop.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  fetch_entry_t     push_entry,
    input  logic             pop,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output fetch_entry_t     head
);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_entry;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_comb begin
        count = count_q;
        head  = mem_q[rd_ptr_q];
    end

    // The fetch credit rule must make both of these unreachable.
    assert property (@(posedge clk) disable iff (reset)
        !(push && !flush && count_q == CNT_W'(DEPTH)));
    assert property (@(posedge clk) disable iff (reset)
        !(pop && !flush && count_q == '0));

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: owns the fetch PC, issues code memory reads under a queue credit limit and
// presents buffered instructions to the core; redirects flush and restart at the target.
module inst_fetch
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned MEM_AW = 3
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_en,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [INST_W-1:0] mem_rdata,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst,
    output logic [PC_W-1:0]   inst_pc,
    input  logic              inst_ready
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [PC_W-1:0]  fetch_pc_q;
    logic [PC_W-1:0]  req_pc_q;
    logic             inflight_q;
    logic [PC_W-1:0]  issue_pc;
    logic [CNT_W-1:0] count;
    logic [CNT_W:0]   used;
    logic             push;
    logic             pop;
    fetch_entry_t     push_entry;
    fetch_entry_t     head;
    logic             unused_pc_lsbs;

    always_comb begin
        issue_pc   = redirect_valid ? {redirect_pc[PC_W-1:2], 2'b00} : fetch_pc_q;
        inst_valid = !reset && (count != '0);
        pop        = inst_valid && inst_ready && !redirect_valid;
        push       = inflight_q && !redirect_valid && !reset;
        // Entries already buffered plus the one in flight, less the one leaving now.
        used       = (CNT_W + 1)'(count) + (CNT_W + 1)'(inflight_q) - (CNT_W + 1)'(pop);
        mem_en     = !reset && (redirect_valid || used < (CNT_W + 1)'(DEPTH));
        mem_addr   = issue_pc[MEM_AW+1:2];
        push_entry = '{inst: mem_rdata, pc: req_pc_q};
        inst       = head.inst;
        inst_pc    = head.pc;
    end

    assign unused_pc_lsbs = ^redirect_pc[1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= '0;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
        end else if (mem_en) begin
            fetch_pc_q <= issue_pc + PC_W'(PC_STEP);
            req_pc_q   <= issue_pc;
            inflight_q <= 1'b1;
        end else begin
            inflight_q <= 1'b0;
        end
    end

    fetch_queue #(
        .DEPTH(DEPTH)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_entry(push_entry),
        .pop       (pop),
        .flush     (redirect_valid),
        .count     (count),
        .head      (head)
    );

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: per-cycle vector table plus a delivery scoreboard and a random
// backpressure run.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_en;
    logic [2:0]  mem_addr;
    logic [31:0] mem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;

    int nvec  = 0;
    int nfail = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        en;
        logic [2:0]  addr;
        logic        iv;
        logic [31:0] ipc;
    } vec_t;

    vec_t vt[$];

    always #5 clk = ~clk;

    inst_fetch #(
        .DEPTH (2),
        .MEM_AW(3)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .mem_en        (mem_en),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .inst_valid    (inst_valid),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .inst_ready    (inst_ready)
    );

    // Code memory: word k holds 0xE000_0000 + k, one-cycle read latency.
    always @(posedge clk) begin
        mem_rdata <= mem_en ? (32'hE000_0000 + {29'd0, mem_addr}) : 32'hDEAD_BEEF;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic rdy, input logic rv,
                                input logic [31:0] rpc, input logic en, input logic [2:0] addr,
                                input logic iv, input logic [31:0] ipc);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
        v.en = en; v.addr = addr; v.iv = iv; v.ipc = ipc;
        return v;
    endfunction

    // Scoreboard: every consumed instruction must be the next expected PC and its memory word.
    always @(negedge clk) begin
        logic [31:0] e;
        if (inst_valid === 1'b1 && inst_ready === 1'b1 && redirect_valid === 1'b0) begin
            if (exp_q.size() == 0) begin
                nvec++;
                nfail++;
                $display("FAIL sb_extra: unexpected delivery pc %h at %0t", inst_pc, $time);
            end else begin
                e = exp_q.pop_front();
                check("sb_pc", inst_pc, e);
                check("sb_inst", inst, 32'hE000_0000 + ((e >> 2) & 32'd7));
            end
        end
    end

    initial begin
        logic        hold;
        logic [31:0] hold_pc;

        reset          = 1'b1;
        inst_ready     = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        //             rst rdy rv rpc     en addr iv ipc
        vt.push_back(mk(1, 1, 0, 0,      0, 0, 0, 0));
        vt.push_back(mk(1, 1, 0, 0,      0, 0, 0, 0));
        vt.push_back(mk(0, 1, 0, 0,      1, 0, 0, 0));      // c0
        vt.push_back(mk(0, 1, 0, 0,      1, 1, 0, 0));
        vt.push_back(mk(0, 0, 0, 0,      0, 0, 1, 0));      // c2 backpressure
        vt.push_back(mk(0, 0, 0, 0,      0, 0, 1, 0));
        vt.push_back(mk(0, 0, 0, 0,      0, 0, 1, 0));
        vt.push_back(mk(0, 1, 0, 0,      1, 2, 1, 0));      // c5 release
        vt.push_back(mk(0, 1, 0, 0,      1, 3, 1, 32'h04));
        vt.push_back(mk(0, 1, 0, 0,      1, 4, 1, 32'h08));
        vt.push_back(mk(0, 1, 0, 0,      1, 5, 1, 32'h0C));
        vt.push_back(mk(0, 1, 0, 0,      1, 6, 1, 32'h10));
        vt.push_back(mk(0, 1, 0, 0,      1, 7, 1, 32'h14));
        vt.push_back(mk(0, 1, 1, 32'h10, 1, 4, 1, 32'h18)); // c11 redirect
        vt.push_back(mk(0, 1, 0, 0,      1, 5, 0, 0));
        vt.push_back(mk(0, 1, 0, 0,      1, 6, 1, 32'h10));
        vt.push_back(mk(0, 1, 0, 0,      1, 7, 1, 32'h14));
        vt.push_back(mk(0, 1, 1, 32'h13, 1, 4, 1, 32'h18)); // c15 misaligned redirect
        vt.push_back(mk(0, 1, 0, 0,      1, 5, 0, 0));
        vt.push_back(mk(0, 1, 0, 0,      1, 6, 1, 32'h10));
        vt.push_back(mk(0, 1, 0, 0,      1, 7, 1, 32'h14));
        vt.push_back(mk(0, 1, 0, 0,      1, 0, 1, 32'h18)); // address wraps
        vt.push_back(mk(0, 1, 0, 0,      1, 1, 1, 32'h1C));
        vt.push_back(mk(0, 1, 0, 0,      1, 2, 1, 32'h20));
        vt.push_back(mk(0, 1, 0, 0,      1, 3, 1, 32'h24));
        vt.push_back(mk(1, 1, 0, 0,      0, 0, 0, 0));      // c23 reset mid-stream
        vt.push_back(mk(0, 1, 0, 0,      1, 0, 0, 0));
        vt.push_back(mk(0, 1, 0, 0,      1, 1, 0, 0));
        vt.push_back(mk(0, 1, 0, 0,      1, 2, 1, 0));
        vt.push_back(mk(0, 1, 0, 0,      1, 3, 1, 32'h04));

        foreach (exp_q_init[i]) exp_q.push_back(exp_q_init[i]);

        @(posedge clk);
        #1;
        for (int i = 0; i < vt.size(); i++) begin
            reset          = vt[i].rst;
            inst_ready     = vt[i].rdy;
            redirect_valid = vt[i].rv;
            redirect_pc    = vt[i].rpc;
            @(negedge clk);
            check($sformatf("v%0d_mem_en", i), 32'(mem_en), 32'(vt[i].en));
            if (vt[i].en) check($sformatf("v%0d_mem_addr", i), 32'(mem_addr), 32'(vt[i].addr));
            check($sformatf("v%0d_inst_valid", i), 32'(inst_valid), 32'(vt[i].iv));
            if (vt[i].iv) check($sformatf("v%0d_inst_pc", i), inst_pc, vt[i].ipc);
            @(posedge clk);
            #1;
        end

        // Clean restart, then random backpressure over a long sequential stream.
        redirect_valid = 1'b0;
        inst_ready     = 1'b0;
        reset          = 1'b1;
        @(negedge clk);
        check("drained", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int k = 0; k < 128; k++) exp_q.push_back(32'(k * 4));
        hold    = 1'b0;
        hold_pc = '0;
        for (int c = 0; c < 120; c++) begin
            inst_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (hold) begin
                check("bp_valid", 32'(inst_valid), 32'd1);
                check("bp_pc", inst_pc, hold_pc);
            end
            hold    = inst_valid && !inst_ready;
            hold_pc = inst_pc;
            @(posedge clk);
            #1;
        end
        check("rand_progress", 32'(exp_q.size() < 100), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    // Deliveries expected from the vector table, in order.
    logic [31:0] exp_q_init [16] = '{
        32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14,
        32'h10, 32'h14,
        32'h10, 32'h14, 32'h18, 32'h1C, 32'h20, 32'h24,
        32'h00, 32'h04
    };

endmodule
